alu_seq: RTL and testbench

Parametrised, registered successor to the 8-bit combinational datapath ALU.
- Adds a start/busy/done handshake, an internal carry flag register, iterative (one bit per cycle) shifts and an iterative unsigned multiplier.
- Sits in the execute stage; the controller holds issue while busy_o is high.

---
 rtl/alu_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered, parametrised execute-stage ALU. It has a start/busy/done
//            handshake, a carry flag register, iterative one-bit-per-cycle
//            shifts and an iterative shift-add unsigned multiplier.
// Ports    : clk         - clock; all state changes on the rising edge
//            reset       - asynchronous active-high reset
//            start_i     - issue request, accepted only while idle
//            op_i        - 4-bit opcode, sampled at acceptance
//            rs_i, rt_i  - operands (rs_i is the shift amount for SL/SR)
//            busy_o      - a multi-cycle op is in progress
//            done_o      - one-cycle pulse when result/flags update
//            result_o    - result register (low half of the MUL product)
//            result_hi_o - high half of the MUL product, 0 after other ops
//            carry_o     - carry/borrow flag
//            z_o         - zero flag
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             carry_o,
  output logic             z_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_CLR = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_SL  = 4'd5;
  localparam logic [3:0] OP_SR  = 4'd6;
  localparam logic [3:0] OP_SET = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_ADC = 4'd10;
  localparam logic [3:0] OP_SBB = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_XOR = 4'd13;
  localparam logic [3:0] OP_CMP = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // MUL: {partial, multiplier}; SHIFT: low half
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               shl_q, shl_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               carry_q, carry_d;
  logic               z_q, z_d;

  logic [WIDTH:0]     w_cin, w_add, w_sub, w_adc, w_sbb, w_inc, w_dec;
  logic [CW-1:0]      w_k;
  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH-1:0]   w_res;
  logic               w_wr;

  // All arithmetic at WIDTH+1 bits: bit WIDTH is carry out, or borrow for
  // subtraction since a negative difference sets the top bit.
  assign w_cin = {{WIDTH{1'b0}}, carry_q};
  assign w_add = {1'b0, rs_i} + {1'b0, rt_i};
  assign w_sub = {1'b0, rs_i} - {1'b0, rt_i};
  assign w_adc = w_add + w_cin;
  assign w_sbb = w_sub - w_cin;
  assign w_inc = {1'b0, rs_i} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec = {1'b0, rs_i} - {{WIDTH{1'b0}}, 1'b1};

  // Shift distance saturates at WIDTH; beyond that the result is all zeros.
  assign w_k = (rs_i >= WIDTH'(WIDTH)) ? CW'(WIDTH) : rs_i[CW-1:0];

  assign w_shifted = shl_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};

  // Shift-add step: add the multiplicand when the multiplier LSB is set, then
  // shift the whole {partial, multiplier} pair right by one.
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    shl_d    = shl_q;
    done_d   = 1'b0;
    result_d = result_q;
    hi_d     = hi_q;
    carry_d  = carry_q;
    z_d      = z_q;
    w_res    = '0;
    w_wr     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_CLR: begin w_res = '0;                w_wr = 1'b1; end
            OP_ADD: begin w_res = w_add[WIDTH-1:0];  carry_d = w_add[WIDTH]; w_wr = 1'b1; end
            OP_SUB: begin w_res = w_sub[WIDTH-1:0];  carry_d = w_sub[WIDTH]; w_wr = 1'b1; end
            OP_AND: begin w_res = rs_i & rt_i;       w_wr = 1'b1; end
            OP_OR:  begin w_res = rs_i | rt_i;       w_wr = 1'b1; end
            OP_XOR: begin w_res = rs_i ^ rt_i;       w_wr = 1'b1; end
            OP_SET: begin w_res = rs_i;              w_wr = 1'b1; end
            OP_INC: begin w_res = w_inc[WIDTH-1:0];  carry_d = w_inc[WIDTH]; w_wr = 1'b1; end
            OP_DEC: begin w_res = w_dec[WIDTH-1:0];  carry_d = w_dec[WIDTH]; w_wr = 1'b1; end
            OP_ADC: begin w_res = w_adc[WIDTH-1:0];  carry_d = w_adc[WIDTH]; w_wr = 1'b1; end
            OP_SBB: begin w_res = w_sbb[WIDTH-1:0];  carry_d = w_sbb[WIDTH]; w_wr = 1'b1; end
            OP_SL, OP_SR: begin
              if (w_k == '0) begin
                w_res = rt_i;
                w_wr  = 1'b1;
              end else begin
                state_d = ST_SHIFT;
                cnt_d   = w_k;
                acc_d   = {{WIDTH{1'b0}}, rt_i};
                shl_d   = (op_i == OP_SL);
              end
            end
            OP_MUL: begin
              state_d = ST_MUL;
              cnt_d   = CW'(WIDTH);
              acc_d   = {{WIDTH{1'b0}}, rt_i};
              mcand_d = rs_i;
            end
            OP_CMP: begin
              // Flags only; the result register keeps its previous value.
              carry_d = w_sub[WIDTH];
              z_d     = (w_sub[WIDTH-1:0] == '0);
              hi_d    = '0;
              done_d  = 1'b1;
            end
            default: ;  // NOP: nothing changes, no done pulse
          endcase
        end
      end
      ST_SHIFT: begin
        acc_d = {{WIDTH{1'b0}}, w_shifted};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          w_res   = w_shifted;
          w_wr    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d = w_mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          result_d = w_mul_next[WIDTH-1:0];
          hi_d     = w_mul_next[2*WIDTH-1:WIDTH];
          carry_d  = |w_mul_next[2*WIDTH-1:WIDTH];
          z_d      = (w_mul_next[WIDTH-1:0] == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Common completion path for every result-writing non-MUL op.
    if (w_wr) begin
      result_d = w_res;
      hi_d     = '0;
      z_d      = (w_res == '0);
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      shl_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      carry_q  <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      shl_q    <= shl_d;
      done_q   <= done_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      carry_q  <= carry_d;
      z_q      <= z_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign result_hi_o = hi_q;
  assign carry_o     = carry_q;
  assign z_o         = z_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq at WIDTH=8 and WIDTH=16, with
//            directed cases and random stimulus against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  op;
  logic [15:0] rs, rt;
  logic        start8, start16;

  logic        busy8, done8, c8, z8;
  logic [7:0]  res8, hi8;
  logic        busy16, done16, c16, z16;
  logic [15:0] res16, hi16;

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start_i(start8), .op_i(op),
    .rs_i(rs[7:0]), .rt_i(rt[7:0]),
    .busy_o(busy8), .done_o(done8), .result_o(res8), .result_hi_o(hi8),
    .carry_o(c8), .z_o(z8)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .start_i(start16), .op_i(op),
    .rs_i(rs), .rt_i(rt),
    .busy_o(busy16), .done_o(done16), .result_o(res16), .result_hi_o(hi16),
    .carry_o(c16), .z_o(z16)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Architectural state expected from each DUT: index 0 = WIDTH 8, 1 = WIDTH 16.
  longint m_res[2];
  longint m_hi[2];
  bit     m_c[2];
  bit     m_z[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int s, output logic b, output logic d,
                        output logic [63:0] r, output logic [63:0] h,
                        output logic c, output logic z);
    if (s == 1) begin
      b = busy16; d = done16; r = {48'h0, res16}; h = {48'h0, hi16}; c = c16; z = z16;
    end else begin
      b = busy8;  d = done8;  r = {56'h0, res8};  h = {56'h0, hi8};  c = c8;  z = z8;
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 1) start16 = v; else start8 = v;
  endtask

  // Issue one op at the current negedge and follow it to completion. Returns
  // at the negedge of the done cycle, so consecutive calls issue back-to-back.
  task automatic run(input int w, input int opc, input longint a_in,
                     input longint b_in, input bit poke);
    int     s;
    longint msk, a, b, r, h, full;
    bit     c, z, pulse;
    int     lat;
    logic   sb, sd, sc, sz;
    logic [63:0] sr, sh;
    s     = (w == 16) ? 1 : 0;
    msk   = (longint'(1) << w) - 1;
    a     = a_in & msk;
    b     = b_in & msk;
    r     = m_res[s];
    h     = m_hi[s];
    c     = m_c[s];
    z     = m_z[s];
    pulse = 1'b1;
    lat   = 0;
    case (opc)
      0:  r = 0;
      1:  begin full = a + b; r = full & msk; c = (full > msk); end
      2:  begin r = (a - b) & msk; c = (a < b); end
      3:  r = a & b;
      4:  r = a | b;
      13: r = a ^ b;
      5, 6: begin
        lat = (a > w) ? w : int'(a);
        r   = (opc == 5) ? ((b << lat) & msk) : (b >> lat);
      end
      7:  r = a;
      8:  begin full = a + 1; r = full & msk; c = (full > msk); end
      9:  begin r = (a - 1) & msk; c = (a == 0); end
      10: begin full = a + b + c; r = full & msk; c = (full > msk); end
      11: begin r = (a - b - c) & msk; c = (a < b + c); end
      12: begin full = a * b; r = full & msk; h = full >> w; c = (h != 0); lat = w; end
      14: begin c = (a < b); z = (((a - b) & msk) == 0); end
      default: pulse = 1'b0;
    endcase
    if (pulse && opc != 12) h = 0;
    if (pulse && opc != 14) z = (r == 0);

    op = opc[3:0];
    rs = a[15:0];
    rt = b[15:0];
    set_start(s, 1'b1);
    @(negedge clk);
    for (int i = 0; i < lat; i++) begin
      set_start(s, 1'b0);
      sample(s, sb, sd, sr, sh, sc, sz);
      check($sformatf("w%0d op%0d busy[%0d]", w, opc, i), {63'h0, sb}, 64'h1);
      check($sformatf("w%0d op%0d early done[%0d]", w, opc, i), {63'h0, sd}, 64'h0);
      check($sformatf("w%0d op%0d held result[%0d]", w, opc, i), sr, m_res[s]);
      if (poke && i == 2) begin
        // A start while busy must be ignored entirely.
        set_start(s, 1'b1);
        op = 4'd1;
        rs = 16'($urandom);
        rt = 16'($urandom);
      end
      @(negedge clk);
    end
    set_start(s, 1'b0);
    sample(s, sb, sd, sr, sh, sc, sz);
    check($sformatf("w%0d op%0d busy end", w, opc), {63'h0, sb}, 64'h0);
    check($sformatf("w%0d op%0d done", w, opc), {63'h0, sd}, {63'h0, pulse});
    check($sformatf("w%0d op%0d result", w, opc), sr, r);
    check($sformatf("w%0d op%0d result_hi", w, opc), sh, h);
    check($sformatf("w%0d op%0d carry", w, opc), {63'h0, sc}, {63'h0, c});
    check($sformatf("w%0d op%0d zero", w, opc), {63'h0, sz}, {63'h0, z});
    m_res[s] = r;
    m_hi[s]  = h;
    m_c[s]   = c;
    m_z[s]   = z;
  endtask

  task automatic check_zero(input int s, input string tag);
    logic sb, sd, sc, sz;
    logic [63:0] sr, sh;
    sample(s, sb, sd, sr, sh, sc, sz);
    check({tag, " busy"},   {63'h0, sb}, 64'h0);
    check({tag, " done"},   {63'h0, sd}, 64'h0);
    check({tag, " result"}, sr, 64'h0);
    check({tag, " hi"},     sh, 64'h0);
    check({tag, " carry"},  {63'h0, sc}, 64'h0);
    check({tag, " zero"},   {63'h0, sz}, 64'h0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      m_res[i] = 0; m_hi[i] = 0; m_c[i] = 1'b0; m_z[i] = 1'b0;
    end
  endtask

  task automatic random_ops(input int w, input int count);
    int     o;
    longint a, b;
    for (int n = 0; n < count; n++) begin
      o = $urandom_range(0, 15);
      a = longint'($urandom);
      b = longint'($urandom);
      if ((o == 5 || o == 6) && $urandom_range(0, 3) != 0) a = $urandom_range(0, w + 2);
      run(w, o, a, b, ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    start8  = 1'b0;
    start16 = 1'b0;
    op      = 4'd0;
    rs      = '0;
    rt      = '0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check_zero(0, "reset w8");
    check_zero(1, "reset w16");
    reset = 1'b0;

    // Back-to-back single-cycle arithmetic.
    run(8, 1,  'hF0, 'h20, 1'b0);
    run(8, 10, 'h01, 'h01, 1'b0);
    run(8, 2,  'h05, 'h05, 1'b0);
    // Iterative shifts, including saturated and zero distance.
    run(8, 5,  3,    'h81, 1'b0);
    run(8, 6,  9,    'hA5, 1'b0);
    run(8, 5,  0,    'h5A, 1'b0);
    // Multiplier, with an ignored start mid-op on the first.
    run(8, 12, 3,    4,    1'b1);
    run(8, 12, 'hFF, 'hFF, 1'b0);
    // Borrow chain, compare, and no-op.
    run(8, 11, 'h00, 'h00, 1'b0);
    run(8, 14, 'h10, 'h10, 1'b0);
    run(8, 15, 'h33, 'h44, 1'b0);

    // Asynchronous reset in the third busy cycle of a multiply.
    op     = 4'd12;
    rs     = 16'h00FF;
    rt     = 16'h0033;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("rstmul busy", {63'h0, busy8}, 64'h1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_zero(0, "rstmul async");
    @(negedge clk);
    check("rstmul no done", {63'h0, done8}, 64'h0);
    reset = 1'b0;
    clear_model();
    run(8, 1, 'h12, 'h34, 1'b0);

    random_ops(8, 150);

    // WIDTH=16 instance.
    run(16, 12, 'hFFFF, 'h0002, 1'b0);
    run(16, 8,  'hFFFF, 'h0000, 1'b0);
    random_ops(16, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
